// File: rtl/pipe_freeze_ctrl_pkg.sv
// Shared pipeline definitions: freeze-controller FSM encodings, the NOP word
// inserted on a flush, and the fetch-address increment.
package pipe_freeze_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/pipe_freeze_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// It sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Count one per cycle while inc is high, holding once all-ones is reached.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is always assigned with <= so every register samples
    // pre-edge values and the simulation matches the synthesized flops.
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_freeze_ctrl.sv
// Pipeline freeze controller: owns the PC and the IF/ID register, freezes
// fetch on a RAW hazard, squashes IF/ID on a taken branch, and tells the
// ID/EX stage when to insert a bubble. Two saturating counters record the
// number of stall cycles and branch flushes.
module pipe_freeze_ctrl
  import pipe_freeze_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  input  logic [31:0]      instr_in,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic [31:0] pc_plus4;
  logic        stall_inc;
  logic        flush_inc;

  // Wraps modulo 2^32 with no carry out, which is the intended behaviour.
  assign pc_plus4 = pc_q + PC_INC;

  // A branch squashes any concurrent hazard, so that cycle is not a stall.
  assign stall_inc = hazard_detected & ~branch_taken;
  assign flush_inc = branch_taken;

  // Next state depends only on this cycle's request: reset, branch, hazard,
  // then normal advance. The unused encoding 2'd3 therefore falls back to RUN
  // on the next advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (branch_taken) begin
      state_q      <= ST_FLUSH;
      pc_q         <= branch_addr;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else if (hazard_detected) begin
      // PC and IF/ID hold their values while the consumer waits.
      state_q <= ST_STALL;
    end else begin
      state_q      <= ST_RUN;
      pc_q         <= pc_plus4;
      ifid_pc_q    <= pc_plus4;
      ifid_instr_q <= instr_in;
      ifid_valid_q <= 1'b1;
    end
  end

  // Bubble ID/EX on reset, on a hazard, on a branch, and for the cycle
  // following a branch while the squashed slot drains.
  assign idex_bubble = rst | hazard_detected | branch_taken | (state_q == ST_FLUSH);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  assign pc         = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pipe_freeze_ctrl.sv
// Directed bench for pipe_freeze_ctrl. A behavioural model predicts the
// registered outputs for each driven cycle; predictions are queued and popped
// after the clock edge. A second instance with 2-bit counters and a PC near
// the top of the address space covers saturation and PC wrap.
module tb_pipe_freeze_ctrl;
  import pipe_freeze_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;
  localparam logic [31:0] I_A = 32'h1111_0013;
  localparam logic [31:0] I_B = 32'h2222_0013;
  localparam logic [31:0] I_C = 32'h3333_0013;
  localparam logic [31:0] I_D = 32'h4444_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        rst, hazard_detected, branch_taken;
  logic [31:0] branch_addr, instr_in;
  logic [31:0] pc, ifid_pc, ifid_instr;
  logic        ifid_valid, idex_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_freeze_ctrl dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .instr_in(instr_in),
    .pc(pc), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .idex_bubble(idex_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance
  logic        rst2, hz2, br2;
  logic [31:0] br_addr2;
  logic [31:0] pc2, ifid_pc2, ifid_instr2;
  logic        ifid_valid2, idex_bubble2;
  logic [1:0]  state2, stall_cnt2, flush_cnt2;

  pipe_freeze_ctrl #(.RESET_PC(RESET_PC2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .hazard_detected(hz2),
    .branch_taken(br2), .branch_addr(br_addr2), .instr_in(I_D),
    .pc(pc2), .ifid_pc(ifid_pc2), .ifid_instr(ifid_instr2), .ifid_valid(ifid_valid2),
    .idex_bubble(idex_bubble2), .state(state2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
  logic        m_ifid_valid;
  state_e      m_state;
  logic [15:0] m_stall, m_flush;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the main instance, predict its effect, then compare.
  task automatic step(input logic r, input logic h, input logic b,
                      input logic [31:0] addr, input logic [31:0] instr,
                      input string tag);
    exp_t e;
    exp_t got;
    rst = r; hazard_detected = h; branch_taken = b;
    branch_addr = addr; instr_in = instr;
    #1;
    check({tag, ".bubble"}, 64'(idex_bubble), 64'(r | h | b | (m_state == ST_FLUSH)));
    if (r) begin
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = 32'h0; m_ifid_valid = 1'b0;
      m_state = ST_RUN; m_stall = 16'h0; m_flush = 16'h0;
    end else if (b) begin
      m_pc = addr; m_ifid_pc = 32'h0; m_ifid_instr = 32'h0; m_ifid_valid = 1'b0;
      m_state = ST_FLUSH;
      if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end else if (h) begin
      m_state = ST_STALL;
      if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end else begin
      m_ifid_pc = m_pc + 32'd4; m_ifid_instr = instr; m_ifid_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_state = ST_RUN;
    end
    e.tag = tag; e.pc = m_pc; e.ifid_pc = m_ifid_pc; e.ifid_instr = m_ifid_instr;
    e.ifid_valid = m_ifid_valid; e.state = m_state;
    e.stall_cnt = m_stall; e.flush_cnt = m_flush;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({got.tag, ".pc"},         64'(pc),         64'(got.pc));
    check({got.tag, ".ifid_pc"},    64'(ifid_pc),    64'(got.ifid_pc));
    check({got.tag, ".ifid_instr"}, 64'(ifid_instr), 64'(got.ifid_instr));
    check({got.tag, ".ifid_valid"}, 64'(ifid_valid), 64'(got.ifid_valid));
    check({got.tag, ".state"},      64'(state),      64'(got.state));
    check({got.tag, ".stall_cnt"},  64'(stall_cnt),  64'(got.stall_cnt));
    check({got.tag, ".flush_cnt"},  64'(flush_cnt),  64'(got.flush_cnt));
    @(negedge clk);
  endtask

  // Drive one cycle on the narrow instance; caller checks afterwards.
  task automatic cyc2(input logic r, input logic h, input logic b, input logic [31:0] addr);
    @(negedge clk);
    rst2 = r; hz2 = h; br2 = b; br_addr2 = addr;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends even if the clock loop misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; hazard_detected = 1'b0; branch_taken = 1'b0;
    branch_addr = 32'h0; instr_in = 32'h0;
    rst2 = 1'b1; hz2 = 1'b0; br2 = 1'b0; br_addr2 = 32'h0;
    m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = 32'h0; m_ifid_valid = 1'b0;
    m_state = ST_RUN; m_stall = 16'h0; m_flush = 16'h0;
    @(negedge clk);

    // Reset, then three free-running fetches.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "rst0");
    check("rst0.pc_lit", 64'(pc), 64'h0);
    check("rst0.valid_lit", 64'(ifid_valid), 64'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, I_A, "adv_a");
    step(1'b0, 1'b0, 1'b0, 32'h0, I_B, "adv_b");
    step(1'b0, 1'b0, 1'b0, 32'h0, I_C, "adv_c");
    check("free3.pc", 64'(pc), 64'h0C);
    check("free3.ifid_instr", 64'(ifid_instr), 64'(I_C));
    check("free3.ifid_pc", 64'(ifid_pc), 64'h0C);
    check("free3.counters", 64'({stall_cnt, flush_cnt}), 64'h0);

    // Two-cycle hazard at pc=0x08, then release.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "rst1");
    step(1'b0, 1'b0, 1'b0, 32'h0, I_A, "pre_a");
    step(1'b0, 1'b0, 1'b0, 32'h0, I_B, "pre_b");
    check("stall.pc_before", 64'(pc), 64'h08);
    step(1'b0, 1'b1, 1'b0, 32'h0, I_C, "haz1");
    step(1'b0, 1'b1, 1'b0, 32'h0, I_C, "haz2");
    check("stall.pc_held", 64'(pc), 64'h08);
    check("stall.ifid_instr_held", 64'(ifid_instr), 64'(I_B));
    check("stall.cnt", 64'(stall_cnt), 64'd2);
    step(1'b0, 1'b0, 1'b0, 32'h0, I_C, "release");
    check("stall.pc_after", 64'(pc), 64'h0C);
    check("stall.state_after", 64'(state), 64'(ST_RUN));

    // Branch wins over a concurrent hazard.
    step(1'b0, 1'b1, 1'b1, 32'h100, I_D, "br_haz");
    check("br_haz.pc", 64'(pc), 64'h100);
    check("br_haz.state", 64'(state), 64'(ST_FLUSH));
    check("br_haz.flush_cnt", 64'(flush_cnt), 64'd1);
    check("br_haz.stall_cnt", 64'(stall_cnt), 64'd2);
    hazard_detected = 1'b0; branch_taken = 1'b0;
    #1;
    check("flush.bubble_idle", 64'(idex_bubble), 64'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0, I_D, "flush_exit");
    check("flush_exit.pc", 64'(pc), 64'h104);

    // Back-to-back branches, then a hazard straight out of FLUSH.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "rst2");
    step(1'b0, 1'b0, 1'b1, 32'h100, I_A, "br1");
    step(1'b0, 1'b0, 1'b1, 32'h200, I_B, "br2");
    check("b2b.pc", 64'(pc), 64'h200);
    check("b2b.state", 64'(state), 64'(ST_FLUSH));
    check("b2b.flush_cnt", 64'(flush_cnt), 64'd2);
    check("b2b.valid", 64'(ifid_valid), 64'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, I_C, "flush_to_stall");
    check("flush_to_stall.state", 64'(state), 64'(ST_STALL));

    // Reset overrides hazard and branch while stalled.
    step(1'b1, 1'b1, 1'b1, 32'h300, I_D, "rst_mid_stall");
    check("rst_mid.pc", 64'(pc), 64'h0);
    check("rst_mid.state", 64'(state), 64'(ST_RUN));
    check("rst_mid.counters", 64'({stall_cnt, flush_cnt}), 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "rst_only");
    rst = 1'b0;

    // Narrow counters saturate; PC wraps past 0xFFFF_FFFC.
    cyc2(1'b1, 1'b0, 1'b0, 32'h0);
    check("n.rst_pc", 64'(pc2), 64'(RESET_PC2));
    check("n.rst_stall", 64'(stall_cnt2), 64'h0);
    for (int i = 0; i < 3; i++) cyc2(1'b0, 1'b1, 1'b0, 32'h0);
    check("n.stall3", 64'(stall_cnt2), 64'd3);
    cyc2(1'b0, 1'b1, 1'b0, 32'h0);
    cyc2(1'b0, 1'b1, 1'b0, 32'h0);
    check("n.stall5_sat", 64'(stall_cnt2), 64'd3);
    check("n.stall_pc_held", 64'(pc2), 64'(RESET_PC2));
    cyc2(1'b0, 1'b0, 1'b0, 32'h0);
    check("n.adv1_pc", 64'(pc2), 64'hFFFF_FFFC);
    cyc2(1'b0, 1'b0, 1'b0, 32'h0);
    check("n.wrap_pc", 64'(pc2), 64'h0);
    check("n.wrap_ifid_pc", 64'(ifid_pc2), 64'h0);
    check("n.wrap_valid", 64'(ifid_valid2), 64'h1);
    for (int i = 0; i < 4; i++) cyc2(1'b0, 1'b0, 1'b1, 32'h40);
    check("n.flush4_sat", 64'(flush_cnt2), 64'd3);
    check("n.flush_pc", 64'(pc2), 64'h40);
    check("n.flush_instr", 64'(ifid_instr2), 64'h0);
    check("n.stall_after", 64'(stall_cnt2), 64'd3);
    rst2 = 1'b1;
    #1;
    check("n.rst_bubble", 64'(idex_bubble2), 64'h1);

    check("sb.empty", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
